inst_axi_rd_bridge: RTL

//  Instruction-side bridge directly upstream of if_stage. Converts the

---
 rtl/inst_axi_rd_bridge_pkg.sv | 22 ++
 rtl/inst_axi_rd_bridge_chk.sv | 24 ++
 rtl/inst_axi_rd_bridge_rd_outs_tracker.sv | 63 ++++++
 rtl/inst_axi_rd_bridge.sv | 134 +++++++++++++
 4 files changed

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI encodings, bus widths and FSM state type for the instruction-side
// AXI read bridge.
package inst_axi_rd_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_W     = 3'd2;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_WAIT = 1'b1
  } ar_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/inst_axi_rd_bridge_chk.sv
// Simulation-only protocol checks for the instruction read bridge: no write
// requests from IF, and the outstanding/discard counters stay consistent.
module inst_axi_rd_bridge_chk #(
  parameter int MAX_OUTS = 2,
  parameter int CNT_W    = 2
) (
  input logic             clk,
  input logic             resetn,
  input logic             req,
  input logic             wr,
  input logic [CNT_W-1:0] outs_cnt,
  input logic [CNT_W-1:0] disc_cnt
);

  a_no_write: assert property (@(posedge clk) disable iff (!resetn) !(req && wr))
    else $error("inst_axi_rd_bridge: write request on instruction port");

  a_outs_max: assert property (@(posedge clk) disable iff (!resetn) outs_cnt <= CNT_W'(MAX_OUTS))
    else $error("inst_axi_rd_bridge: outstanding count above limit");

  a_disc_le_outs: assert property (@(posedge clk) disable iff (!resetn) disc_cnt <= outs_cnt)
    else $error("inst_axi_rd_bridge: discard count exceeds outstanding count");

endmodule

// File: rtl/inst_axi_rd_bridge_rd_outs_tracker.sv
// Outstanding-read and discard bookkeeping: counts reads accepted on AR but not
// yet returned on R, and how many of those returns must be swallowed after a flush.
module rd_outs_tracker #(
  parameter int MAX_OUTS = 2,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ar_hs,
  input  logic             ar_pend,
  input  logic             r_hs,
  input  logic             cancel,
  output logic             full,
  output logic             drop_beat,
  output logic [CNT_W-1:0] outs_cnt,
  output logic [CNT_W-1:0] disc_cnt
);

  logic [CNT_W-1:0] outs_next_s;
  logic [CNT_W-1:0] disc_next_s;
  logic             late_cancel_r;
  logic             late_cancel_next_s;

  assign full      = outs_cnt >= CNT_W'(MAX_OUTS);
  assign drop_beat = disc_cnt != {CNT_W{1'b0}};

  // Next counts; an AR stuck in AR_WAIT at flush time owes one discard on its handshake.
  always_comb begin
    outs_next_s        = outs_cnt + CNT_W'(ar_hs) - CNT_W'(r_hs);
    disc_next_s        = disc_cnt;
    late_cancel_next_s = late_cancel_r;
    if (cancel) begin
      disc_next_s        = outs_next_s;
      late_cancel_next_s = ar_pend && !ar_hs;
    end else begin
      if (r_hs && drop_beat) begin
        disc_next_s = disc_cnt - CNT_W'(1);
      end else begin
        disc_next_s = disc_cnt;
      end
      if (ar_hs && late_cancel_r) begin
        disc_next_s        = disc_next_s + CNT_W'(1);
        late_cancel_next_s = 1'b0;
      end else begin
        late_cancel_next_s = late_cancel_r;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outs_cnt      <= {CNT_W{1'b0}};
      disc_cnt      <= {CNT_W{1'b0}};
      late_cancel_r <= 1'b0;
    end else begin
      outs_cnt      <= outs_next_s;
      disc_cnt      <= disc_next_s;
      late_cancel_r <= late_cancel_next_s;
    end
  end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side bridge: inst_sram-like req/addrok/dataok reads to an AXI4
// read-only master, dropping in-flight data after an exception flush.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] ARID_VAL = 4'd0,
  parameter int                  MAX_OUTS = 2,
  parameter int                  CNT_W    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_sram_req,
  input  logic                  inst_sram_wr,
  input  logic [1:0]            inst_sram_size,
  input  logic [AXI_ADDR_W-1:0] inst_sram_addr,
  input  logic [3:0]            inst_sram_wstrb,
  input  logic [AXI_DATA_W-1:0] inst_sram_wdata,
  output logic                  inst_sram_addrok,
  output logic                  inst_sram_dataok,
  output logic [AXI_DATA_W-1:0] inst_sram_rdata,
  input  logic                  ws_cancel,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [AXI_ID_W-1:0]   rid,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  inst_bus_err
);

  ar_state_t        state_r;
  logic             accept_s;
  logic             ar_hs_s;
  logic             r_hs_s;
  logic             full_s;
  logic             drop_beat_s;
  logic [CNT_W-1:0] outs_cnt_s;
  logic [CNT_W-1:0] disc_cnt_s;
  logic             unused_s;

  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign rready  = 1'b1;

  // addrok must never look at req: IF builds req from it.
  assign inst_sram_addrok = resetn && (state_r == AR_IDLE) && !full_s && !ws_cancel;
  assign accept_s         = inst_sram_req && inst_sram_addrok && !inst_sram_wr;
  assign ar_hs_s          = arvalid && arready;
  assign r_hs_s           = rvalid && rready;

  assign inst_sram_dataok = rvalid && !drop_beat_s && !ws_cancel;
  assign inst_sram_rdata  = rdata;
  assign inst_bus_err     = inst_sram_dataok && resp_is_err(rresp);

  assign unused_s = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  // AR channel FSM with registered valid and payload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= AR_IDLE;
      arvalid <= 1'b0;
      araddr  <= 32'h0000_0000;
      arsize  <= AXI_SIZE_W;
    end else begin
      case (state_r)
        AR_IDLE: begin
          if (accept_s) begin
            state_r <= AR_WAIT;
            arvalid <= 1'b1;
            araddr  <= inst_sram_addr;
            arsize  <= {1'b0, inst_sram_size};
          end else begin
            arvalid <= 1'b0;
          end
        end
        AR_WAIT: begin
          if (arready) begin
            state_r <= AR_IDLE;
            arvalid <= 1'b0;
          end else begin
            arvalid <= 1'b1;
          end
        end
        default: begin
          state_r <= AR_IDLE;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

  rd_outs_tracker #(
    .MAX_OUTS (MAX_OUTS),
    .CNT_W    (CNT_W)
  ) u_trk (
    .clk       (clk),
    .resetn    (resetn),
    .ar_hs     (ar_hs_s),
    .ar_pend   (arvalid),
    .r_hs      (r_hs_s),
    .cancel    (ws_cancel),
    .full      (full_s),
    .drop_beat (drop_beat_s),
    .outs_cnt  (outs_cnt_s),
    .disc_cnt  (disc_cnt_s)
  );

  inst_axi_rd_bridge_chk #(
    .MAX_OUTS (MAX_OUTS),
    .CNT_W    (CNT_W)
  ) u_chk (
    .clk      (clk),
    .resetn   (resetn),
    .req      (inst_sram_req),
    .wr       (inst_sram_wr),
    .outs_cnt (outs_cnt_s),
    .disc_cnt (disc_cnt_s)
  );

endmodule
